// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: controller state encoding
// and the iteration-counter preload helper used by both the controller and the datapath top.
package mult_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_STEP_SH  = 3'd2;
    localparam logic [2:0] ST_STEP_ADD = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        LOAD     = ST_LOAD,
        STEP_SH  = ST_STEP_SH,
        STEP_ADD = ST_STEP_ADD,
        DONE     = ST_DONE
    } state_t;

    // Preload so the up-counter reaches all ones (co) on the N-th iteration.
    function automatic logic [31:0] cnt_preload(input int unsigned n, input int unsigned m);
        logic [31:0] full;
        full = 32'd1 << m;
        return (full - n) & (full - 32'd1);
    endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Control/handshake bundle between the multiplier controller and its datapath/requester.
// Handshake: start is a level request honoured only while ready=1; done marks a valid product in P.
interface shift_add_mult_ctrl_if #(parameter int M = 6);
    logic         start;
    logic         qmsb;
    logic         co;
    logic         ack;
    logic         ready;
    logic         done;
    logic         ld_a;
    logic         ld_q;
    logic         clr_p;
    logic         sh_p;
    logic         ld_p;
    logic         sh_q;
    logic         cnt_ld;
    logic         cnt_en;
    logic [M-1:0] cnt_pin;
    logic [2:0]   fsm_state;

    modport master (
        output start, qmsb, co, ack,
        input  ready, done, ld_a, ld_q, clr_p, sh_p, ld_p, sh_q,
               cnt_ld, cnt_en, cnt_pin, fsm_state
    );

    modport slave (
        input  start, qmsb, co, ack,
        output ready, done, ld_a, ld_q, clr_p, sh_p, ld_p, sh_q,
               cnt_ld, cnt_en, cnt_pin, fsm_state
    );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for the serial shift-and-add multiplier (load, N shift/add iterations, done).
// Optional feature: define DONE_HOLD_EN to hold DONE until ack.
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int N = 5,
    parameter int M = 6
) (
    input logic                   clk,
    input logic                   rst,
    shift_add_mult_ctrl_if.slave  bus
);

    localparam logic [31:0] PIN_FULL = cnt_preload(N, M);

    state_t state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:     if (bus.start) state <= LOAD;
                LOAD:     state <= STEP_SH;
                STEP_SH:  state <= STEP_ADD;
                STEP_ADD: state <= bus.co ? DONE : STEP_SH;
`ifdef DONE_HOLD_EN
                DONE:     if (bus.ack) state <= IDLE;
`else
                DONE:     state <= IDLE;
`endif
                default:  state <= IDLE;
            endcase
        end
    end

`ifndef DONE_HOLD_EN
    logic unused_ack;
    assign unused_ack = bus.ack;
`endif

    // Moore decode from the state register; ld_p additionally gated by the current multiplier bit.
    always_comb begin
        bus.ready  = 1'b0;
        bus.done   = 1'b0;
        bus.ld_a   = 1'b0;
        bus.ld_q   = 1'b0;
        bus.clr_p  = 1'b0;
        bus.sh_p   = 1'b0;
        bus.ld_p   = 1'b0;
        bus.sh_q   = 1'b0;
        bus.cnt_ld = 1'b0;
        bus.cnt_en = 1'b0;
        case (state)
            IDLE: bus.ready = 1'b1;
            LOAD: begin
                bus.ld_a   = 1'b1;
                bus.ld_q   = 1'b1;
                bus.clr_p  = 1'b1;
                bus.cnt_ld = 1'b1;
            end
            STEP_SH: bus.sh_p = 1'b1;
            STEP_ADD: begin
                bus.ld_p   = bus.qmsb;
                bus.sh_q   = 1'b1;
                bus.cnt_en = 1'b1;
            end
            DONE:    bus.done = 1'b1;
            default: bus.ready = 1'b0;
        endcase
    end

    assign bus.cnt_pin   = PIN_FULL[M-1:0];
    assign bus.fsm_state = state;

endmodule
